// File: rtl/tff_modulo_counter.sv
// Modulo up/down counter built on a toggle flip-flop bank (Q <= Q ^ T), exporting T.
// Define TFF_CNT_SATURATE_EN to hold at the boundary instead of wrapping.
module tff_modulo_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic             C,
   input  logic             R,
   input  logic             E,
   input  logic             UP,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             CLR_OVF,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] T,
   output logic             TC,
   output logic             OVF
);

   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
   localparam bit               POW2  = (MODULUS == (32'd1 << WIDTH));

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] t_d;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] cnt_t;
   logic [WIDTH:0]   nxt_up_w;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             at_top, at_bot, boundary;

   assign nxt_up_w = {1'b0, q_q} + (WIDTH+1)'(1);
   assign at_top   = (nxt_up_w == MOD_W);
   assign at_bot   = (q_q == '0);
   assign ld_val   = ({1'b0, D} < MOD_W) ? D : MAX_Q;
   assign boundary = E & ~LD & (UP ? at_top : at_bot);

   // Power-of-two moduli wrap naturally, so the toggle vector is a pure prefix AND/NOR chain.
   if (POW2) begin : g_pow2
      assign cnt_t[0] = 1'b1;
      for (genvar i = 1; i < WIDTH; i++) begin : g_bit
         assign cnt_t[i] = UP ? (&q_q[i-1:0]) : ~(|q_q[i-1:0]);
      end
   end else begin : g_mod
      logic [WIDTH-1:0] nxt;
      always_comb begin
         if (UP) nxt = at_top ? '0 : nxt_up_w[WIDTH-1:0];
         else    nxt = at_bot ? MAX_Q : (q_q - WIDTH'(1));
      end
      assign cnt_t = q_q ^ nxt;
   end

   always_comb begin
      t_d   = '0;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (R) begin
         t_d   = q_q;
         ovf_d = 1'b0;
      end else begin
         if (LD) begin
            t_d = q_q ^ ld_val;
         end else if (E) begin
`ifdef TFF_CNT_SATURATE_EN
            t_d = boundary ? '0 : cnt_t;
`else
            t_d = cnt_t;
`endif
            tc_d = boundary;
         end
         if (boundary)     ovf_d = 1'b1;
         else if (CLR_OVF) ovf_d = 1'b0;
      end
   end

   assign q_d = q_q ^ t_d;

   always_ff @(posedge C) begin
      if (R) begin
         q_q   <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign Q   = q_q;
   assign T   = t_d;
   assign TC  = tc_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_tff_modulo_counter.sv
// Scoreboard bench for tff_modulo_counter: MODULUS=16 and MODULUS=10 instances, directed vectors.
// Saturation expectations are selected by TFF_CNT_SATURATE_EN.
module tb_tff_modulo_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       r0, e0, up0, ld0, clr0, tc0, ovf0;
   logic [3:0] d0, q0, t0;
   logic       r1, e1, up1, ld1, clr1, tc1, ovf1;
   logic [3:0] d1, q1, t1;

   tff_modulo_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
      .C(clk), .R(r0), .E(e0), .UP(up0), .LD(ld0), .D(d0), .CLR_OVF(clr0),
      .Q(q0), .T(t0), .TC(tc0), .OVF(ovf0)
   );

   tff_modulo_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
      .C(clk), .R(r1), .E(e1), .UP(up1), .LD(ld1), .D(d1), .CLR_OVF(clr1),
      .Q(q1), .T(t1), .TC(tc1), .OVF(ovf1)
   );

   typedef struct {
      string      name;
      bit         sel;
      bit         chk_t;
      logic [3:0] t;
      logic [3:0] q;
      logic       tc;
      logic       ovf;
   } exp_item_t;

   exp_item_t sb[$];
   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      {r0, e0, up0, ld0, clr0} = '0; d0 = '0;
      {r1, e1, up1, ld1, clr1} = '0; d1 = '0;
   end

   task automatic chk(input string nm, input string f, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got %b, expected %b", nm, f, act, exp);
      end
   endtask

   // Drive one cycle on the selected instance (other instance idles) and queue its expectation.
   task automatic cyc(input string nm, input bit sel, input logic r, e, up, ld,
                      input logic [3:0] d, input logic clr, input bit ct,
                      input logic [3:0] et, eq, input logic etc, eovf);
      exp_item_t it;
      @(negedge clk);
      {r0, e0, up0, ld0, clr0} = '0; d0 = '0;
      {r1, e1, up1, ld1, clr1} = '0; d1 = '0;
      if (sel) begin
         r1 = r; e1 = e; up1 = up; ld1 = ld; d1 = d; clr1 = clr;
      end else begin
         r0 = r; e0 = e; up0 = up; ld0 = ld; d0 = d; clr0 = clr;
      end
      it.name = nm; it.sel = sel; it.chk_t = ct;
      it.t = et; it.q = eq; it.tc = etc; it.ovf = eovf;
      sb.push_back(it);
   endtask

   // Monitor: T is checked before the edge, Q/TC/OVF just after it.
   initial begin
      exp_item_t it;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            it = sb.pop_front();
            if (it.chk_t) chk(it.name, "T", it.sel ? t1 : t0, it.t);
            @(posedge clk);
            #1;
            chk(it.name, "Q",   it.sel ? q1 : q0, it.q);
            chk(it.name, "TC",  {3'b000, it.sel ? tc1 : tc0}, {3'b000, it.tc});
            chk(it.name, "OVF", {3'b000, it.sel ? ovf1 : ovf0}, {3'b000, it.ovf});
         end
      end
   end

   initial begin
      //  name          sel r  e  up ld d      clr ct T      Q      TC OVF
      cyc("rst16",      0, 1, 0, 0, 0, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      for (int i = 0; i < 15; i++)
         cyc("up16",    0, 0, 1, 1, 0, 4'h0, 0,  1, 4'(i ^ (i + 1)), 4'(i + 1), 0, 0);
`ifdef TFF_CNT_SATURATE_EN
      for (int i = 0; i < 3; i++)
         cyc("sat16",   0, 0, 1, 1, 0, 4'h0, 0,  1, 4'h0, 4'hF, 1, 1);
      cyc("clr16",      0, 0, 0, 0, 0, 4'h0, 1,  1, 4'h0, 4'hF, 0, 0);
`else
      cyc("wrap16",     0, 0, 1, 1, 0, 4'h0, 0,  1, 4'hF, 4'h0, 1, 1);
      cyc("idle16",     0, 0, 0, 1, 0, 4'h0, 0,  1, 4'h0, 4'h0, 0, 1);
      cyc("dnwrap16",   0, 0, 1, 0, 0, 4'h0, 0,  1, 4'hF, 4'hF, 1, 1);
      cyc("setwins16",  0, 0, 1, 1, 0, 4'h0, 1,  1, 4'hF, 4'h0, 1, 1);
      cyc("clr16",      0, 0, 0, 0, 0, 4'h0, 1,  1, 4'h0, 4'h0, 0, 0);
      cyc("rst10",      1, 1, 0, 0, 0, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      cyc("dnwrap10",   1, 0, 1, 0, 0, 4'h0, 0,  1, 4'h9, 4'h9, 1, 1);
      cyc("dn10_9to8",  1, 0, 1, 0, 0, 4'h0, 0,  1, 4'h1, 4'h8, 0, 1);
      cyc("dn10_8to7",  1, 0, 1, 0, 0, 4'h0, 0,  1, 4'hF, 4'h7, 0, 1);
      cyc("up10_7to8",  1, 0, 1, 1, 0, 4'h0, 0,  1, 4'hF, 4'h8, 0, 1);
      cyc("up10_8to9",  1, 0, 1, 1, 0, 4'h0, 0,  1, 4'h1, 4'h9, 0, 1);
      cyc("upwrap10",   1, 0, 1, 1, 0, 4'h0, 0,  1, 4'h9, 4'h0, 1, 1);
`endif
      cyc("rst10b",     1, 1, 0, 0, 0, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      cyc("ldclamp12",  1, 0, 1, 1, 1, 4'hC, 0,  1, 4'h9, 4'h9, 0, 0);
      cyc("ld3",        1, 0, 0, 0, 1, 4'h3, 0,  1, 4'hA, 4'h3, 0, 0);
      cyc("ld9",        1, 0, 0, 0, 1, 4'h9, 0,  1, 4'hA, 4'h9, 0, 0);
      cyc("ldclamp10",  1, 0, 0, 0, 1, 4'hA, 0,  1, 4'h0, 4'h9, 0, 0);
      cyc("rst16b",     0, 1, 0, 0, 0, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      cyc("ld6",        0, 0, 0, 0, 1, 4'h6, 0,  1, 4'h6, 4'h6, 0, 0);
      cyc("up6to7",     0, 0, 1, 1, 0, 4'h0, 0,  1, 4'h1, 4'h7, 0, 0);
      cyc("rstmid",     0, 1, 1, 1, 0, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      cyc("resume",     0, 0, 1, 1, 0, 4'h0, 0,  1, 4'h1, 4'h1, 0, 0);
      cyc("ld15",       0, 0, 0, 0, 1, 4'hF, 0,  1, 4'hE, 4'hF, 0, 0);
      cyc("rstdroptc",  0, 1, 1, 1, 0, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      cyc("hold16",     0, 0, 0, 1, 0, 4'h0, 0,  1, 4'h0, 4'h0, 0, 0);

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
